// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data memory arbiter.
//   arb_state_e : two-state arbiter FSM (IDLE, ACCESS)
//   DMEM_AW     : default memory address width
//   DMEM_DW     : default memory data width
//   idx_width() : width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   localparam int DMEM_AW = 8;
   localparam int DMEM_DW = 8;

   // A single requester still needs a 1-bit index so the vectors stay legal.
   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Starting just above the priority pointer
// and wrapping modulo NREQ, it selects the first asserted request.
// Ports:
//   req_i     : request vector (NREQ bits)
//   ptr_i     : index of the previous winner (search starts at ptr_i+1)
//   win_oh_o  : one-hot winner, all zero when nothing is requested
//   win_idx_o : binary index of the winner (0 when nothing is requested)
//   any_o     : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_oh_o,
   output logic [IW-1:0]   win_idx_o,
   output logic            any_o
);

   int   scan_s;
   logic found_s;

   // Scan NREQ positions beginning one above the pointer; the pointer itself is checked last.
   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      found_s   = 1'b0;
      scan_s    = 0;
      for (int i = 1; i <= NREQ; i++) begin
         scan_s = (int'(ptr_i) + i) % NREQ;
         if (!found_s && req_i[scan_s[IW-1:0]]) begin
            found_s                     = 1'b1;
            win_oh_o[scan_s[IW-1:0]]    = 1'b1;
            win_idx_o                   = scan_s[IW-1:0];
         end else begin
            found_s = found_s;
         end
      end
      any_o = found_s;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Round-robin arbiter sharing the single-port data memory between NREQ
// requesters. A command sampled in IDLE is registered onto the memory pins and
// executed in the following ACCESS cycle, where gnt pulses; read data is
// captured at the end of ACCESS and returned with a one-cycle rvalid pulse.
// Optional feature macro: DMEM_ARB_LOCK_EN (bus locking via the lock port).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   req, req_wr          : per-requester request and write flag
//   req_addr, req_wdata  : packed per-requester address / write data
//   lock                 : keep ownership after the access (lock build only)
//   gnt, rvalid          : one-hot command-accepted / read-data-valid pulses
//   rdata                : registered read data, held between reads
//   mem_addr, mem_wdata, mem_wr : registered memory command pins
//   mem_rdata            : combinational read data from the memory
// -----------------------------------------------------------------------------
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = DMEM_AW,
   parameter int DW   = DMEM_DW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_wr,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   input  logic [NREQ-1:0]    lock,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic               mem_wr,
   input  logic [DW-1:0]      mem_rdata
);

   localparam int IW = idx_width(NREQ);

   arb_state_e      state_q,     state_d;
   logic [IW-1:0]   ptr_q,       ptr_d;
   logic [IW-1:0]   win_idx_q,   win_idx_d;
   logic [NREQ-1:0] gnt_q,       gnt_d;
   logic [NREQ-1:0] rvalid_q,    rvalid_d;
   logic [DW-1:0]   rdata_q,     rdata_d;
   logic [AW-1:0]   mem_addr_q,  mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            mem_wr_q,    mem_wr_d;

   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] pick_oh_s;
   logic [IW-1:0]   pick_idx_s;
   logic            pick_any_s;

`ifdef DMEM_ARB_LOCK_EN
   logic lock_q, lock_d;

   // While the owner still holds lock, only the owner may win; dropping lock frees the bus in that same IDLE cycle.
   always_comb begin
      if (lock_q && lock[win_idx_q]) begin
         elig_s = req & (NREQ'(1) << win_idx_q);
      end else begin
         elig_s = req;
      end
   end

   // Lock is captured when the winner is granted (ACCESS) and released in the first IDLE cycle with lock low.
   always_comb begin
      lock_d = lock_q;
      if (state_q == ACCESS) begin
         lock_d = lock[win_idx_q];
      end else if (lock_q && !lock[win_idx_q]) begin
         lock_d = 1'b0;
      end else begin
         lock_d = lock_q;
      end
   end

   // Lock ownership register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   logic unused_lock_s;

   // Without locking every request is eligible; the lock port is intentionally ignored.
   always_comb begin
      elig_s        = req;
      unused_lock_s = ^lock;
   end
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req_i     (elig_s),
      .ptr_i     (ptr_q),
      .win_oh_o  (pick_oh_s),
      .win_idx_o (pick_idx_s),
      .any_o     (pick_any_s)
   );

   // FSM next state plus next values of every registered output.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_idx_d   = win_idx_q;
      gnt_d       = '0;
      rvalid_d    = '0;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any_s) begin
               // gnt is registered here so it pulses during the ACCESS cycle that executes the command.
               state_d     = ACCESS;
               ptr_d       = pick_idx_s;
               win_idx_d   = pick_idx_s;
               gnt_d       = pick_oh_s;
               mem_wr_d    = req_wr[pick_idx_s];
               mem_addr_d  = req_addr[int'(pick_idx_s)*AW +: AW];
               mem_wdata_d = req_wdata[int'(pick_idx_s)*DW +: DW];
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = IDLE;
            if (!mem_wr_q) begin
               rdata_d             = mem_rdata;
               rvalid_d[win_idx_q] = 1'b1;
            end else begin
               rdata_d = rdata_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer and output registers; the pointer resets so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= IW'(NREQ-1);
         win_idx_q   <= '0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_idx_q   <= win_idx_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with NREQ=4, including a behavioural
// model of data_mem (synchronous write, combinational read).
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_wr;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    lock;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic               mem_wr;
   logic [DW-1:0]      mem_rdata;

   logic [7:0] mem [0:255];
   logic       pre_we;
   logic [7:0] pre_addr;
   logic [7:0] pre_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .lock      (lock),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata)
   );

   // data_mem model: the bench preload port takes precedence over the arbiter.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_wr) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; lock = '0; req_wr = '0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; req_wr = '0; lock = '0;
      repeat (3) tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
      checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus: got addr %h data %h expected 00 00", mem_addr, mem_wdata); end
      rst_n = 1'b1;
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_winner: got %b expected 0001", gnt); end
      req = '0;
      tick();
      checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL reset_first_rvalid: got %b expected 0001", rvalid); end
   endtask

   task automatic test_single_read();
      preload(8'h3C, 8'hA5);
      req_addr = {8'h00, 8'h00, 8'h3C, 8'h00};
      req_wr = '0;
      req = 4'b0010;
      tick();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL read_gnt: got %b expected 0010", gnt); end
      checks++; if (mem_addr !== 8'h3C || mem_wr !== 1'b0) begin errors++; $display("FAIL read_mem_cmd: got addr %h wr %b expected 3c 0", mem_addr, mem_wr); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL read_early_rvalid: got %b expected 0000", rvalid); end
      req = '0;
      tick();
      checks++; if (rvalid !== 4'b0010 || rdata !== 8'hA5) begin errors++; $display("FAIL read_data: got rvalid %b rdata %h expected 0010 a5", rvalid, rdata); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL read_gnt_pulse: got %b expected 0000", gnt); end
      tick();
      checks++; if (rvalid !== 4'b0000 || rdata !== 8'hA5) begin errors++; $display("FAIL read_hold: got rvalid %b rdata %h expected 0000 a5", rvalid, rdata); end
   endtask

   task automatic test_write_readback();
      int wr_cycles;
      wr_cycles = 0;
      req_addr  = {8'h00, 8'h00, 8'h10, 8'h10};
      req_wdata = {8'h00, 8'h00, 8'h00, 8'h5A};
      req_wr = 4'b0001;
      req = 4'b0001;
      tick();
      if (mem_wr === 1'b1) wr_cycles++;
      checks++; if (gnt !== 4'b0001 || mem_addr !== 8'h10 || mem_wdata !== 8'h5A) begin errors++; $display("FAIL write_cmd: got gnt %b addr %h data %h expected 0001 10 5a", gnt, mem_addr, mem_wdata); end
      req = '0; req_wr = '0;
      tick();
      if (mem_wr === 1'b1) wr_cycles++;
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL write_no_rvalid: got %b expected 0000", rvalid); end
      req = 4'b0010;
      tick();
      if (mem_wr === 1'b1) wr_cycles++;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL readback_gnt: got %b expected 0010", gnt); end
      req = '0;
      tick();
      checks++; if (rvalid !== 4'b0010 || rdata !== 8'h5A) begin errors++; $display("FAIL readback_data: got rvalid %b rdata %h expected 0010 5a", rvalid, rdata); end
      checks++; if (wr_cycles != 1) begin errors++; $display("FAIL write_pulse_len: got %0d cycles expected 1", wr_cycles); end
   endtask

   task automatic test_contention();
      logic [NREQ-1:0] exp_oh;
      logic [7:0]      exp_data;
      for (int i = 0; i < NREQ; i++) preload(8'h40 + 8'(i), 8'hC0 + 8'(i));
      do_reset();
      req_addr = {8'h43, 8'h42, 8'h41, 8'h40};
      req_wr = '0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_oh   = 4'b0001 << (k % 4);
         exp_data = 8'hC0 + 8'(k % 4);
         tick();
         checks++; if (gnt !== exp_oh || rvalid !== 4'b0000) begin errors++; $display("FAIL contention_gnt[%0d]: got gnt %b rvalid %b expected %b 0000", k, gnt, rvalid, exp_oh); end
         if (k == 4) req = '0;
         tick();
         checks++; if (gnt !== 4'b0000 || rvalid !== exp_oh || rdata !== exp_data) begin errors++; $display("FAIL contention_rd[%0d]: got gnt %b rvalid %b rdata %h expected 0000 %b %h", k, gnt, rvalid, rdata, exp_oh, exp_data); end
      end
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL contention_stop: got %b expected 0000", gnt); end
   endtask

   task automatic test_reset_mid_access();
      preload(8'h20, 8'h00);
      req_addr[7:0]  = 8'h20;
      req_wdata[7:0] = 8'h77;
      req_wr = 4'b0001;
      req = 4'b0001;
      tick();
      checks++; if (gnt !== 4'b0001 || mem_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd: got gnt %b wr %b expected 0001 1", gnt, mem_wr); end
      rst_n = 1'b0; req = '0; req_wr = '0;
      tick();
      checks++; if (mem[8'h20] !== 8'h77) begin errors++; $display("FAIL rst_mid_write_landed: got %h expected 77", mem[8'h20]); end
      checks++; if (gnt !== 4'b0000 || rvalid !== 4'b0000 || mem_wr !== 1'b0 || mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_outputs: got gnt %b rvalid %b wr %b addr %h expected 0000 0000 0 00", gnt, rvalid, mem_wr, mem_addr); end
      tick();
      checks++; if (gnt !== 4'b0000 || rvalid !== 4'b0000) begin errors++; $display("FAIL rst_mid_quiet: got gnt %b rvalid %b expected 0000 0000", gnt, rvalid); end
      rst_n = 1'b1;
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_mid_next_winner: got %b expected 0001", gnt); end
      req = '0;
      tick();
      checks++; if (rvalid !== 4'b0001 || rdata !== 8'h77) begin errors++; $display("FAIL rst_mid_readback: got rvalid %b rdata %h expected 0001 77", rvalid, rdata); end
   endtask

   task automatic test_lock();
      do_reset();
      req_addr = {8'h43, 8'h42, 8'h41, 8'h40};
      req_wr = '0;
      lock = 4'b0100;
      req = 4'b0100;
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_first_gnt: got %b expected 0100", gnt); end
      req = 4'b0101;
      tick();
      checks++; if (rvalid !== 4'b0100 || rdata !== 8'hC2) begin errors++; $display("FAIL lock_first_rd: got rvalid %b rdata %h expected 0100 c2", rvalid, rdata); end
`ifdef DMEM_ARB_LOCK_EN
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_hold_gnt[%0d]: got %b expected 0100", k, gnt); end
         if (k == 1) req = 4'b0001;
         tick();
         checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL lock_hold_rd[%0d]: got %b expected 0100", k, rvalid); end
      end
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_blocks_other: got %b expected 0000", gnt); end
      lock = '0;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_release_gnt: got %b expected 0001", gnt); end
      req = '0;
      tick();
      checks++; if (rvalid !== 4'b0001 || rdata !== 8'hC0) begin errors++; $display("FAIL lock_release_rd: got rvalid %b rdata %h expected 0001 c0", rvalid, rdata); end
`else
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL nolock_rr_gnt: got %b expected 0001", gnt); end
      req = 4'b0100;
      tick();
      checks++; if (rvalid !== 4'b0001 || rdata !== 8'hC0) begin errors++; $display("FAIL nolock_rr_rd: got rvalid %b rdata %h expected 0001 c0", rvalid, rdata); end
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL nolock_back_gnt: got %b expected 0100", gnt); end
      req = '0;
      tick();
      checks++; if (rvalid !== 4'b0100) begin errors++; $display("FAIL nolock_back_rd: got %b expected 0100", rvalid); end
`endif
      lock = '0;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; req_wr = '0; lock = '0;
      req_addr = '0; req_wdata = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      test_reset();
      test_single_read();
      test_write_readback();
      test_contention();
      test_reset_mid_access();
      test_lock();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
